ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline; the consumer of the decode stage's ALUop/operand/write-control bundle, registered by the ID/EX latch.
- Computes GPR and HI/LO results, effective memory addresses and store data.
- Drives the EX bypass bus back into decode.
- Contains a multi-cycle iterative divider; holds the pipeline via pauseRequest while the divider is busy.

Parameters:
- DIV_CYCLES, 32, number of iteration cycles per divide; equals the data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ALUop_i  in  5  ALU_* operation code
- oprand1_i  in  32  operand 1 (rs / HI / LO)
- oprand2_i  in  32  operand 2 (rt or immediate)
- signed_i  in  1  divide is signed
- writeAddr_i  in  5  GPR destination
- writeEnable_i  in  1  GPR write request
- writeHILO_i  in  2  {HI,LO} write request
- inst_i  in  32  instruction word; offset field used for memory ops
- stall_i  in  1  downstream stall from the pipeline controller
- flush_i  in  1  annul the instruction in EX
- writeAddr_o  out  5  GPR destination (bypass and EX/MEM)
- writeEnable_o  out  1  GPR write valid
- writeHILO_o  out  2  HI/LO write valid
- writeHI_data_o  out  32  HI result
- writeLO_data_o  out  32  LO result; also carries the GPR result
- ramOp_o  out  4  MEM_* code; MEM_NOP when not a memory op
- ramAddr_o  out  32  effective address
- ramData_o  out  32  store data
- pauseRequest_o  out  1  hold IF/ID/EX stages

Behaviour:
- Reset: rst is synchronous, active-high. While rst=1 every output is 0, ramOp_o=MEM_NOP, and the divider FSM is forced to IDLE with its counter cleared.
- Non-divide ops are combinational from the inputs (zero added latency), so the bypass is valid in the same cycle the instruction sits in EX.
- ALU_OR: writeLO_data_o = op1|op2.
- ALU_MOV: writeHI_data_o = writeLO_data_o = op1.
- ALU_MULT: signed 32x32 -> 64 product. HI = product[63:32], LO = product[31:0]. Single cycle.
- Loads/stores: ramAddr_o = op1 + sext(inst_i[15:0]), wrapping mod 2^32.
  - Stores: ramData_o = op2.
  - ALU_LW/LB/LH/LBU/LHU/SW/SB/SH map 1:1 to the MEM_* codes.
  - Loads pass writeAddr_i and writeEnable_i through.
- writeEnable_o, writeHILO_o and writeAddr_o pass through from the inputs, except as forced to 0 below.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE + ALU_DIV, divisor != 0: latch |op1|, |op2| and the quotient/remainder signs; cnt=0; go BUSY. pauseRequest_o=1 in this cycle.
  - IDLE + ALU_DIV, divisor == 0: go DONE directly, result LO=0xFFFFFFFF, HI=op1. pauseRequest_o=1 for this single cycle.
  - BUSY: one restoring shift-subtract step per cycle; cnt++; after step DIV_CYCLES go DONE. pauseRequest_o=1 throughout.
  - DONE: pauseRequest_o=0, writeHILO_o=11, LO=quotient, HI=remainder. Signed fixup: quotient is negated if the operand signs differ; the remainder takes the sign of the dividend. If signed_i=0, raw unsigned results are used.
  - DONE + stall_i=1: stay in DONE with the result held. DONE + stall_i=0: go IDLE.
  - Latency: the result appears 33 cycles after the DIV enters EX (1 latch + 32 steps). pauseRequest_o is high for exactly 33 cycles.
  - In IDLE, BUSY, and IDLE-with-DIV, writeHILO_o=00, so no partial result is ever bypassed.
- flush_i=1: FSM goes to IDLE next cycle. Same cycle: writeEnable_o=0, writeHILO_o=00, ramOp_o=MEM_NOP, pauseRequest_o=0.
- rst mid-divide: FSM goes to IDLE; no HI/LO write occurs.
- Back-to-back DIVs: DONE->IDLE, then the next DIV is accepted in IDLE the following cycle.
- The most-negative dividend (0x80000000 / -1) wraps: LO=0x80000000, HI=0.

Decomposition:
- ALU_* and MEM_* codes, plus the FSM state encodings, go in the shared defines include.
- One sub-module, div_iter: FSM, counter, shift/subtract datapath and sign fixup. Its handshake is start/abort/stall in, busy/done/quotient/remainder out.
- ex_stage instantiates div_iter and holds the result muxing.

Test Plan:
- ORI: op1=0x00F0, op2=0x000F, writeAddr=3 -> writeLO_data_o=0x00FF and writeEnable_o=1 in the same cycle; pauseRequest_o=0.
- LW: op1=0x1000, inst offset 0xFFFC -> ramAddr_o=0x0FFC, ramOp_o=MEM_LW. SW with op2=0xDEADBEEF -> ramData_o=0xDEADBEEF.
- DIV signed 100/7 -> pause high 33 cycles, then LO=14, HI=2, writeHILO_o=11. Signed -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV by 0 -> pause high 1 cycle, then LO=0xFFFFFFFF, HI=op1. DIV with stall_i held 3 cycles in DONE -> result stable all 3 cycles.
- MULT 0xFFFFFFFF*2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE, same cycle, no pause.
- rst asserted at BUSY cycle 10 -> next cycle all outputs 0, FSM IDLE. A following DIV 9/3 -> LO=3, HI=0 after 33 cycles.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared operation codes, memory op codes and divider states for the execute stage
package ex_stage_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [4:0] {
    ALU_NOP = 5'd0, ALU_OR, ALU_MOV, ALU_MULT, ALU_DIV,
    ALU_LW, ALU_LB, ALU_LH, ALU_LBU, ALU_LHU, ALU_SW, ALU_SB, ALU_SH
  } alu_op_e;
  typedef enum logic [3:0] {
    MEM_NOP = 4'd0, MEM_LW, MEM_LB, MEM_LH, MEM_LBU, MEM_LHU, MEM_SW, MEM_SB, MEM_SH
  } mem_op_e;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
  function automatic logic [3:0] mem_op(input logic [4:0] op);
    case (op)
      ALU_LW:  return MEM_LW;
      ALU_LB:  return MEM_LB;
      ALU_LH:  return MEM_LH;
      ALU_LBU: return MEM_LBU;
      ALU_LHU: return MEM_LHU;
      ALU_SW:  return MEM_SW;
      ALU_SB:  return MEM_SB;
      ALU_SH:  return MEM_SH;
      default: return MEM_NOP;
    endcase
  endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX bundle into the execute stage and the EX result/bypass bundle out of it
// slave = execute stage (consumes *_i, drives *_o); master = the surrounding pipeline
interface ex_stage_if;
  logic [4:0]  ALUop_i;
  logic [31:0] oprand1_i;
  logic [31:0] oprand2_i;
  logic        signed_i;
  logic [4:0]  writeAddr_i;
  logic        writeEnable_i;
  logic [1:0]  writeHILO_i;
  logic [31:0] inst_i;
  logic        stall_i;
  logic        flush_i;
  logic [4:0]  writeAddr_o;
  logic        writeEnable_o;
  logic [1:0]  writeHILO_o;
  logic [31:0] writeHI_data_o;
  logic [31:0] writeLO_data_o;
  logic [3:0]  ramOp_o;
  logic [31:0] ramAddr_o;
  logic [31:0] ramData_o;
  logic        pauseRequest_o;
  modport master (
    output ALUop_i, oprand1_i, oprand2_i, signed_i, writeAddr_i, writeEnable_i,
           writeHILO_i, inst_i, stall_i, flush_i,
    input  writeAddr_o, writeEnable_o, writeHILO_o, writeHI_data_o, writeLO_data_o,
           ramOp_o, ramAddr_o, ramData_o, pauseRequest_o
  );
  modport slave (
    input  ALUop_i, oprand1_i, oprand2_i, signed_i, writeAddr_i, writeEnable_i,
           writeHILO_i, inst_i, stall_i, flush_i,
    output writeAddr_o, writeEnable_o, writeHILO_o, writeHI_data_o, writeLO_data_o,
           ramOp_o, ramAddr_o, ramData_o, pauseRequest_o
  );
endinterface

// File: rtl/ex_stage_div_iter.sv
// ex_stage_div_iter: iterative restoring 32-bit divider with signed fixup
// in: clk, rst, i_start, i_abort, i_stall, i_signed, i_dividend, i_divisor
// out: o_busy (hold pipeline), o_done (result valid), o_quotient, o_remainder
module ex_stage_div_iter import ex_stage_pkg::*; #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_stall,
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);
  localparam int CW = $clog2(DIV_CYCLES);
  div_state_e r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_quot, r_rem, r_dvs;
  logic r_neg_q, r_neg_r;
  logic w_a_neg, w_b_neg, w_zero, w_accept;
  logic [32:0] w_shift, w_diff;
  assign w_a_neg  = i_signed & i_dividend[31];
  assign w_b_neg  = i_signed & i_divisor[31];
  assign w_zero   = i_divisor == '0;
  assign w_accept = r_state == DIV_IDLE && i_start && !i_abort;
  // r_quot doubles as the dividend shift register; its MSB feeds the partial remainder
  assign w_shift  = {r_rem, r_quot[31]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  always_comb begin
    w_next = i_abort ? DIV_IDLE :
             r_state == DIV_IDLE ? (i_start ? (w_zero ? DIV_DONE : DIV_BUSY) : DIV_IDLE) :
             r_state == DIV_BUSY ? (r_cnt == CW'(DIV_CYCLES - 1) ? DIV_DONE : DIV_BUSY) :
             (i_stall ? DIV_DONE : DIV_IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        // divide-by-zero bypasses the iterations: LO = all ones, HI = raw dividend
        r_cnt   <= '0;
        r_quot  <= w_zero ? '1 : (w_a_neg ? -i_dividend : i_dividend);
        r_rem   <= w_zero ? i_dividend : '0;
        r_dvs   <= w_b_neg ? -i_divisor : i_divisor;
        r_neg_q <= !w_zero && (w_a_neg ^ w_b_neg);
        r_neg_r <= !w_zero && w_a_neg;
      end else if (r_state == DIV_BUSY) begin
        // w_diff[32] is the borrow: set when the shifted remainder is below the divisor
        r_cnt  <= r_cnt + 1'b1;
        r_quot <= {r_quot[30:0], ~w_diff[32]};
        r_rem  <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
      end
    end
  end
  assign o_busy      = (r_state == DIV_IDLE && i_start) || r_state == DIV_BUSY;
  assign o_done      = r_state == DIV_DONE;
  assign o_quotient  = r_neg_q ? -r_quot : r_quot;
  assign o_remainder = r_neg_r ? -r_rem : r_rem;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS32 execute stage - ALU/MULT results, memory address/data, iterative DIV with pipeline pause
// ports: clk, rst (sync, active-high), bus (ex_stage_if.slave: ID/EX bundle in, EX/MEM + bypass bundle out)
module ex_stage import ex_stage_pkg::*; #(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  ex_stage_if.slave bus
);
  logic w_busy, w_done, w_start, w_store, w_unused;
  logic [31:0] w_quot, w_rem, w_addr;
  logic signed [63:0] w_prod;
  assign w_start  = bus.ALUop_i == ALU_DIV;
  assign w_store  = bus.ALUop_i inside {ALU_SW, ALU_SB, ALU_SH};
  assign w_addr   = bus.oprand1_i + {{16{bus.inst_i[15]}}, bus.inst_i[15:0]};
  assign w_prod   = $signed(bus.oprand1_i) * $signed(bus.oprand2_i);
  assign w_unused = ^bus.inst_i[31:16];
  ex_stage_div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div_iter (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_abort     (bus.flush_i),
    .i_stall     (bus.stall_i),
    .i_signed    (bus.signed_i),
    .i_dividend  (bus.oprand1_i),
    .i_divisor   (bus.oprand2_i),
    .o_busy      (w_busy),
    .o_done      (w_done),
    .o_quotient  (w_quot),
    .o_remainder (w_rem)
  );
  always_comb begin
    bus.writeAddr_o    = bus.writeAddr_i;
    bus.writeEnable_o  = bus.writeEnable_i;
    bus.writeHILO_o    = bus.writeHILO_i;
    bus.writeHI_data_o = '0;
    bus.writeLO_data_o = '0;
    bus.ramOp_o        = mem_op(bus.ALUop_i);
    bus.ramAddr_o      = w_addr;
    bus.ramData_o      = w_store ? bus.oprand2_i : '0;
    bus.pauseRequest_o = w_busy && !bus.flush_i;
    case (bus.ALUop_i)
      ALU_OR:   bus.writeLO_data_o = bus.oprand1_i | bus.oprand2_i;
      ALU_MOV:  begin
        bus.writeHI_data_o = bus.oprand1_i;
        bus.writeLO_data_o = bus.oprand1_i;
      end
      ALU_MULT: {bus.writeHI_data_o, bus.writeLO_data_o} = w_prod;
      ALU_DIV:  begin
        // only a finished divide is ever exposed on HI/LO or the bypass
        bus.writeHILO_o    = w_done ? 2'b11 : 2'b00;
        bus.writeHI_data_o = w_done ? w_rem : '0;
        bus.writeLO_data_o = w_done ? w_quot : '0;
      end
      default: ;
    endcase
    if (bus.flush_i) begin
      bus.writeEnable_o = 1'b0;
      bus.writeHILO_o   = 2'b00;
      bus.ramOp_o       = MEM_NOP;
    end
    if (rst) begin
      bus.writeAddr_o    = '0;
      bus.writeEnable_o  = 1'b0;
      bus.writeHILO_o    = 2'b00;
      bus.writeHI_data_o = '0;
      bus.writeLO_data_o = '0;
      bus.ramOp_o        = MEM_NOP;
      bus.ramAddr_o      = '0;
      bus.ramData_o      = '0;
      bus.pauseRequest_o = 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage
module tb_ex_stage;
  import ex_stage_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  ex_stage_if bus();
  ex_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic set_idle();
    bus.ALUop_i = ALU_NOP;
    bus.oprand1_i = '0;
    bus.oprand2_i = '0;
    bus.signed_i = 1'b0;
    bus.writeAddr_i = '0;
    bus.writeEnable_i = 1'b0;
    bus.writeHILO_i = 2'b00;
    bus.inst_i = '0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
  endtask
  task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [31:0] lo, input logic [31:0] hi, input int plen);
    int cnt = 0;
    int bad = 0;
    bus.ALUop_i = ALU_DIV;
    bus.oprand1_i = a;
    bus.oprand2_i = b;
    bus.signed_i = sgn;
    bus.writeHILO_i = 2'b11;
    bus.writeEnable_i = 1'b0;
    #1;
    while (bus.pauseRequest_o === 1'b1 && cnt < 100) begin
      if (bus.writeHILO_o !== 2'b00) bad++;
      cnt++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (cnt !== plen) begin n_errors++; $display("FAIL %s pause_cycles got %0d want %0d", nm, cnt, plen); end
    n_checks++;
    if (bad !== 0) begin n_errors++; $display("FAIL %s partial_hilo got %0d want 0", nm, bad); end
    n_checks++;
    if (bus.writeHILO_o !== 2'b11) begin n_errors++; $display("FAIL %s hilo got %b want 11", nm, bus.writeHILO_o); end
    n_checks++;
    if (bus.writeLO_data_o !== lo) begin n_errors++; $display("FAIL %s lo got %h want %h", nm, bus.writeLO_data_o, lo); end
    n_checks++;
    if (bus.writeHI_data_o !== hi) begin n_errors++; $display("FAIL %s hi got %h want %h", nm, bus.writeHI_data_o, hi); end
  endtask
  task automatic end_div(input string nm);
    bus.ALUop_i = ALU_NOP;
    bus.writeHILO_i = 2'b00;
    @(posedge clk); #1;
    n_checks++;
    if (bus.pauseRequest_o !== 1'b0 || bus.writeHILO_o !== 2'b00) begin
      n_errors++; $display("FAIL %s idle_after got pause=%b hilo=%b want 0 00", nm, bus.pauseRequest_o, bus.writeHILO_o);
    end
  endtask
  task automatic test_reset();
    bus.ALUop_i = ALU_OR;
    bus.oprand1_i = 32'hF0;
    bus.oprand2_i = 32'h0F;
    bus.writeAddr_i = 5'd3;
    bus.writeEnable_i = 1'b1;
    bus.writeHILO_i = 2'b11;
    @(posedge clk); #1;
    n_checks++;
    if (bus.writeLO_data_o !== 32'h0 || bus.writeEnable_o !== 1'b0 || bus.writeAddr_o !== 5'd0 || bus.writeHILO_o !== 2'b00) begin
      n_errors++; $display("FAIL reset_outputs got lo=%h we=%b wa=%h hilo=%b want all 0", bus.writeLO_data_o, bus.writeEnable_o, bus.writeAddr_o, bus.writeHILO_o);
    end
    bus.ALUop_i = ALU_DIV;
    bus.oprand2_i = 32'd7;
    #1;
    n_checks++;
    if (bus.pauseRequest_o !== 1'b0 || bus.ramOp_o !== MEM_NOP) begin
      n_errors++; $display("FAIL reset_pause got pause=%b ramop=%h want 0 0", bus.pauseRequest_o, bus.ramOp_o);
    end
    set_idle();
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.pauseRequest_o !== 1'b0) begin n_errors++; $display("FAIL reset_idle pause got %b want 0", bus.pauseRequest_o); end
  endtask
  task automatic test_ori();
    bus.ALUop_i = ALU_OR;
    bus.oprand1_i = 32'h00F0;
    bus.oprand2_i = 32'h000F;
    bus.writeAddr_i = 5'd3;
    bus.writeEnable_i = 1'b1;
    #1;
    n_checks++;
    if (bus.writeLO_data_o !== 32'h00FF) begin n_errors++; $display("FAIL ori_lo got %h want 000000ff", bus.writeLO_data_o); end
    n_checks++;
    if (bus.writeEnable_o !== 1'b1 || bus.writeAddr_o !== 5'd3) begin
      n_errors++; $display("FAIL ori_we got we=%b wa=%0d want 1 3", bus.writeEnable_o, bus.writeAddr_o);
    end
    n_checks++;
    if (bus.pauseRequest_o !== 1'b0 || bus.ramOp_o !== MEM_NOP) begin
      n_errors++; $display("FAIL ori_side got pause=%b ramop=%h want 0 0", bus.pauseRequest_o, bus.ramOp_o);
    end
    set_idle();
    @(posedge clk); #1;
  endtask
  task automatic test_mem();
    bus.ALUop_i = ALU_LW;
    bus.oprand1_i = 32'h1000;
    bus.inst_i = 32'h8C22FFFC;
    bus.writeAddr_i = 5'd2;
    bus.writeEnable_i = 1'b1;
    #1;
    n_checks++;
    if (bus.ramAddr_o !== 32'h0FFC || bus.ramOp_o !== MEM_LW) begin
      n_errors++; $display("FAIL lw_addr got addr=%h op=%h want 00000ffc %h", bus.ramAddr_o, bus.ramOp_o, MEM_LW);
    end
    n_checks++;
    if (bus.writeEnable_o !== 1'b1 || bus.writeAddr_o !== 5'd2) begin
      n_errors++; $display("FAIL lw_wb got we=%b wa=%0d want 1 2", bus.writeEnable_o, bus.writeAddr_o);
    end
    bus.ALUop_i = ALU_SW;
    bus.oprand1_i = 32'h2000;
    bus.oprand2_i = 32'hDEADBEEF;
    bus.inst_i = 32'hAC220010;
    bus.writeEnable_i = 1'b0;
    #1;
    n_checks++;
    if (bus.ramData_o !== 32'hDEADBEEF || bus.ramAddr_o !== 32'h2010 || bus.ramOp_o !== MEM_SW) begin
      n_errors++; $display("FAIL sw got data=%h addr=%h op=%h want deadbeef 00002010 %h", bus.ramData_o, bus.ramAddr_o, bus.ramOp_o, MEM_SW);
    end
    bus.ALUop_i = ALU_LBU;
    bus.oprand1_i = 32'hFFFFFFF0;
    bus.inst_i = 32'h90220020;
    #1;
    n_checks++;
    if (bus.ramAddr_o !== 32'h10 || bus.ramOp_o !== MEM_LBU) begin
      n_errors++; $display("FAIL lbu_wrap got addr=%h op=%h want 00000010 %h", bus.ramAddr_o, bus.ramOp_o, MEM_LBU);
    end
    set_idle();
    @(posedge clk); #1;
  endtask
  task automatic test_mult();
    bus.ALUop_i = ALU_MULT;
    bus.oprand1_i = 32'hFFFFFFFF;
    bus.oprand2_i = 32'd2;
    bus.writeHILO_i = 2'b11;
    #1;
    n_checks++;
    if (bus.writeHI_data_o !== 32'hFFFFFFFF || bus.writeLO_data_o !== 32'hFFFFFFFE) begin
      n_errors++; $display("FAIL mult got hi=%h lo=%h want ffffffff fffffffe", bus.writeHI_data_o, bus.writeLO_data_o);
    end
    n_checks++;
    if (bus.writeHILO_o !== 2'b11 || bus.pauseRequest_o !== 1'b0) begin
      n_errors++; $display("FAIL mult_ctl got hilo=%b pause=%b want 11 0", bus.writeHILO_o, bus.pauseRequest_o);
    end
    bus.ALUop_i = ALU_MOV;
    bus.oprand1_i = 32'h12345678;
    #1;
    n_checks++;
    if (bus.writeHI_data_o !== 32'h12345678 || bus.writeLO_data_o !== 32'h12345678) begin
      n_errors++; $display("FAIL mov got hi=%h lo=%h want 12345678 12345678", bus.writeHI_data_o, bus.writeLO_data_o);
    end
    set_idle();
    @(posedge clk); #1;
  endtask
  task automatic test_div();
    run_div("div_100_7", 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 33);
    end_div("div_100_7");
    run_div("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    end_div("div_m7_2");
    run_div("div_minneg", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 33);
    end_div("div_minneg");
    run_div("divu_big", 32'hFFFFFFFE, 32'd2, 1'b0, 32'h7FFFFFFF, 32'h0, 33);
    end_div("divu_big");
    run_div("div_7_m3", 32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFE, 32'd1, 33);
    end_div("div_7_m3");
  endtask
  task automatic test_div_zero();
    run_div("div0", 32'd1234, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd1234, 1);
    end_div("div0");
    run_div("div0_neg", 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1);
    end_div("div0_neg");
  endtask
  task automatic test_div_stall();
    run_div("div_stall", 32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 33);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.writeLO_data_o !== 32'd3 || bus.writeHI_data_o !== 32'd2 || bus.writeHILO_o !== 2'b11 || bus.pauseRequest_o !== 1'b0) begin
        n_errors++; $display("FAIL stall_hold%0d got lo=%h hi=%h hilo=%b pause=%b want 3 2 11 0", i, bus.writeLO_data_o, bus.writeHI_data_o, bus.writeHILO_o, bus.pauseRequest_o);
      end
      @(posedge clk); #1;
    end
    bus.stall_i = 1'b0;
    end_div("div_stall");
  endtask
  task automatic test_back_to_back();
    run_div("b2b_first", 32'd50, 32'd8, 1'b1, 32'd6, 32'd2, 33);
    @(posedge clk); #1;
    run_div("b2b_second", 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 33);
    end_div("b2b");
  endtask
  task automatic test_flush();
    bus.ALUop_i = ALU_DIV;
    bus.oprand1_i = 32'd100;
    bus.oprand2_i = 32'd7;
    bus.signed_i = 1'b1;
    bus.writeHILO_i = 2'b11;
    repeat (5) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    bus.writeEnable_i = 1'b1;
    #1;
    n_checks++;
    if (bus.pauseRequest_o !== 1'b0 || bus.writeHILO_o !== 2'b00 || bus.writeEnable_o !== 1'b0) begin
      n_errors++; $display("FAIL flush_same got pause=%b hilo=%b we=%b want 0 00 0", bus.pauseRequest_o, bus.writeHILO_o, bus.writeEnable_o);
    end
    @(posedge clk); #1;
    set_idle();
    #1;
    n_checks++;
    if (bus.pauseRequest_o !== 1'b0) begin n_errors++; $display("FAIL flush_idle pause got %b want 0", bus.pauseRequest_o); end
    bus.ALUop_i = ALU_LW;
    bus.writeEnable_i = 1'b1;
    bus.flush_i = 1'b1;
    #1;
    n_checks++;
    if (bus.ramOp_o !== MEM_NOP || bus.writeEnable_o !== 1'b0) begin
      n_errors++; $display("FAIL flush_lw got op=%h we=%b want 0 0", bus.ramOp_o, bus.writeEnable_o);
    end
    set_idle();
    @(posedge clk); #1;
    run_div("flush_after", 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 33);
    end_div("flush_after");
  endtask
  task automatic test_rst_mid();
    bus.ALUop_i = ALU_DIV;
    bus.oprand1_i = 32'd100;
    bus.oprand2_i = 32'd7;
    bus.signed_i = 1'b1;
    bus.writeHILO_i = 2'b11;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (bus.pauseRequest_o !== 1'b1) begin n_errors++; $display("FAIL rst_mid_busy pause got %b want 1", bus.pauseRequest_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.pauseRequest_o !== 1'b0 || bus.writeHILO_o !== 2'b00 || bus.writeLO_data_o !== 32'h0 || bus.writeHI_data_o !== 32'h0) begin
      n_errors++; $display("FAIL rst_mid_out got pause=%b hilo=%b lo=%h hi=%h want 0 00 0 0", bus.pauseRequest_o, bus.writeHILO_o, bus.writeLO_data_o, bus.writeHI_data_o);
    end
    rst = 1'b0;
    set_idle();
    @(posedge clk); #1;
    n_checks++;
    if (bus.pauseRequest_o !== 1'b0 || bus.writeHILO_o !== 2'b00) begin
      n_errors++; $display("FAIL rst_mid_idle got pause=%b hilo=%b want 0 00", bus.pauseRequest_o, bus.writeHILO_o);
    end
    run_div("rst_after", 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 33);
    end_div("rst_after");
  endtask
  initial begin
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ori();
    test_mem();
    test_mult();
    test_div();
    test_div_zero();
    test_div_stall();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
